bakraid_text_mixer: RTL and testbench
=====================================

// Module: bakraid_text_mixer
// PURPOSE
//  Downstream consumer of the extra-text line renderer's EXTRATEXT_PIXEL stream. Each pixel, it selects the text pixel or the underlying layer pixel.
//  It then reads the selected colour from palette RAM and expands xBGR555 to RGB888.
//  It emits colour plus delayed HB/VB to the video output stage.
//  Runs entirely in the CLK96 domain and is paced by PIXEL_CEN.
// PARAMETERS
//  PAL_AW       11  palette RAM word address width (= pixel index width)
//  PALRAM_LAT   1   palette RAM read latency, CLK96 cycles (1..3)
//  CEN_GAP_MIN  6   minimum CLK96 cycles between PIXEL_CEN pulses; must be >= PALRAM_LAT+3
// PORTS
//  CLK96            in   1       sole clock
//  RESET96          in   1       synchronous, active-high reset
//  PIXEL_CEN        in   1       pixel strobe, one CLK96 wide
//  HB               in   1       horizontal blank, aligned with the pixel inputs
//  VB               in   1       vertical blank, aligned with the pixel inputs
//  EXTRATEXT_PIXEL  in   11      text palette index; idx[3:0]==0 is transparent
//  LAYER_PIXEL      in   11      composited GP9001 layer index; idx[3:0]==0 is transparent
//  PALRAM_ADDR      out  PAL_AW  palette RAM read address
//  PALRAM_DATA      in   16      palette word {x,B[4:0],G[4:0],R[4:0]}
//  RED/GREEN/BLUE   out  8 each  output colour
//  HB_OUT, VB_OUT   out  1 each  blanks delayed to match the colour outputs
//  OVERRUN          out  1       sticky: PIXEL_CEN arrived before the lookup finished
// BEHAVIOUR
//  - Reset: all outputs 0; FSM to IDLE; OVERRUN cleared; the HB/VB delay pipe is preloaded to 1, so HB_OUT/VB_OUT read 1 on the first cycle after reset.
//  - Select on PIXEL_CEN: idx = (EXTRATEXT_PIXEL[3:0]!=0) ? EXTRATEXT_PIXEL : LAYER_PIXEL.
//    Text always wins. HB|VB at that same edge is latched as blank_s.
//  - FSM: IDLE -(PIXEL_CEN)-> ADDR: PALRAM_ADDR<=idx -> WAIT: count PALRAM_LAT cycles -> CAPTURE: latch PALRAM_DATA into col_q -> IDLE.
//  - Output update: on the next PIXEL_CEN, RGB<=blank_s?0:expand(col_q), and HB_OUT/VB_OUT are updated in the same cycle.
//    Fixed latency: 2 PIXEL_CEN strobes from input to output.
//  - Expansion: c8={c5,c5[4:2]}, e.g. 5'h1F->8'hFF, 5'h10->8'h84, 5'h00->8'h00. Bit 15 is ignored.
//  - Both indices transparent: idx=0, which reads palette entry 0 (the backdrop). With the macro off, see CONFIGURATION.
//  - Overrun: PIXEL_CEN while the FSM is not IDLE:
//    - OVERRUN<=1 (sticky until reset);
//    - outputs update with the previous col_q;
//    - the in-flight lookup is aborted and the new pixel starts in ADDR.
//  - Blanking needs no palette read: if blank_s, the FSM still cycles (PALRAM_ADDR<=0) so latency stays uniform.
//  - Reset mid-lookup aborts with no PALRAM side effects. The first two post-reset PIXEL_CENs output 0.
//  - PALRAM_ADDR holds its value outside ADDR. There are no write ports; palette RAM arbitration is external.
// CONFIGURATION
//  - BAKRAID_TEXTMIX_BACKDROP_EN
//    - Defined: both transparent -> palette entry 0 is used (as above).
//    - Undefined: both transparent -> the palette read is skipped (ADDR is not updated), col_q<=16'h0000, and output is black.
//      Latency is unchanged.
// STRUCTURE
//  - Shared package bakraid_video_pkg:
//    - typedef pal_idx_t (logic[10:0]);
//    - typedef xbgr555_t;
//    - function expand5to8;
//    - localparam TRANSP_NIBBLE=4'h0;
//    - FSM state enum (IDLE, ADDR, WAIT, CAPTURE).
//  - One sub-module, bakraid_pal_expand: registered xbgr555_t->RGB888 conversion, enabled by a load strobe.
//    It is reused later by the sprite/BG output paths.
// TESTING
//  - Text over layer: EXT=11'h123, LAYER=11'h045, PALRAM[0x123]=16'h7FFF, then 2 CENs -> RGB=FF/FF/FF, PALRAM_ADDR=0x123.
//  - Text transparent: EXT=11'h120, LAYER=11'h045, PALRAM[0x045]=16'h001F -> R=FF, G=00, B=00.
//  - Both transparent: PALRAM[0]=16'h4210 -> macro on: RGB=84/84/84; macro off: RGB=00/00/00.
//  - Blank: HB=1 with a valid text pixel -> RGB=0 and HB_OUT=1, both exactly 2 CENs later.
//  - Overrun: CEN gap of 2 cycles with PALRAM_LAT=1 -> OVERRUN=1, remains 1 until RESET96.
//    The next normally spaced pixel is still correct.
//  - Reset mid-WAIT: assert RESET96 one cycle -> RGB=0, FSM=IDLE, OVERRUN=0. The next 2 CENs output 0.

Source files
------------

// File: rtl/bakraid_video_pkg.sv
// Shared video-path types: palette index, xBGR555 palette word, 5->8 bit expansion
// and the text-mixer lookup FSM states.
package bakraid_video_pkg;

    typedef logic [10:0] pal_idx_t;

    typedef struct packed {
        logic       x;
        logic [4:0] b;
        logic [4:0] g;
        logic [4:0] r;
    } xbgr555_t;

    localparam logic [3:0] TRANSP_NIBBLE = 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        CAPTURE
    } mix_state_t;

    // Replicating the top bits gives full-scale 0x00..0xFF from 0x00..0x1F.
    function automatic logic [7:0] expand5to8(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

endpackage

// File: rtl/bakraid_pal_expand.sv
// Registered xBGR555 -> RGB888 converter; updates only on load, force_black yields 0.
// One cycle latency from load; no backpressure (strobe driven).
module bakraid_pal_expand
    import bakraid_video_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       force_black,
    input  xbgr555_t   col,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);

    // The spare palette bit carries no colour information.
    logic unused_x;
    assign unused_x = col.x;

    always_ff @(posedge clk) begin
        if (rst) begin
            red   <= 8'h00;
            green <= 8'h00;
            blue  <= 8'h00;
        end else if (load) begin
            if (force_black) begin
                red   <= 8'h00;
                green <= 8'h00;
                blue  <= 8'h00;
            end else begin
                red   <= expand5to8(col.r);
                green <= expand5to8(col.g);
                blue  <= expand5to8(col.b);
            end
        end
    end

endmodule

// File: rtl/bakraid_text_mixer.sv
// Text-over-layer mixer with palette lookup; output lags input by 2 PIXEL_CEN strobes.
// No backpressure: a strobe during a lookup aborts it and sets OVERRUN. Option: BAKRAID_TEXTMIX_BACKDROP_EN.
module bakraid_text_mixer
    import bakraid_video_pkg::*;
#(
    parameter int PAL_AW      = 11,
    parameter int PALRAM_LAT  = 1,
    parameter int CEN_GAP_MIN = 6
) (
    input  logic              CLK96,
    input  logic              RESET96,
    input  logic              PIXEL_CEN,
    input  logic              HB,
    input  logic              VB,
    input  logic [10:0]       EXTRATEXT_PIXEL,
    input  logic [10:0]       LAYER_PIXEL,
    output logic [PAL_AW-1:0] PALRAM_ADDR,
    input  logic [15:0]       PALRAM_DATA,
    output logic [7:0]        RED,
    output logic [7:0]        GREEN,
    output logic [7:0]        BLUE,
    output logic              HB_OUT,
    output logic              VB_OUT,
    output logic              OVERRUN
);

    if (PALRAM_LAT < 1 || PALRAM_LAT > 3 || CEN_GAP_MIN < PALRAM_LAT + 3) begin : g_param_err
        $error("bakraid_text_mixer: PALRAM_LAT must be 1..3 and CEN_GAP_MIN >= PALRAM_LAT+3");
    end

    localparam logic [1:0] LAT_M1 = 2'(PALRAM_LAT - 1);

    mix_state_t state;
    mix_state_t state_nxt;
    logic [1:0] wait_cnt;

    pal_idx_t   idx_sel;
    pal_idx_t   idx_q;
    logic       skip_sel;
    logic       skip_q;
    logic       hb_s;
    logic       vb_s;
    logic       blank_s;
    xbgr555_t   col_q;
    logic [1:0] prime_cnt;
    logic       primed;

    assign idx_sel = (EXTRATEXT_PIXEL[3:0] != TRANSP_NIBBLE) ? EXTRATEXT_PIXEL : LAYER_PIXEL;
    assign blank_s = hb_s | vb_s;
    assign primed  = prime_cnt[1];

`ifdef BAKRAID_TEXTMIX_BACKDROP_EN
    assign skip_sel = 1'b0;
`else
    // Both sources transparent: no read, the pixel is forced to black.
    assign skip_sel = (idx_sel[3:0] == TRANSP_NIBBLE);
`endif

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A strobe always restarts the lookup, whatever state it lands in.
    always_comb begin
        state_nxt = state;
        if (PIXEL_CEN) begin
            state_nxt = ADDR;
        end else begin
            case (state)
                ADDR:    state_nxt = WAIT;
                WAIT:    if (wait_cnt == LAT_M1) state_nxt = CAPTURE;
                CAPTURE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            wait_cnt <= 2'd0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 2'd1;
        end else begin
            wait_cnt <= 2'd0;
        end
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            idx_q       <= '0;
            skip_q      <= 1'b0;
            hb_s        <= 1'b1;
            vb_s        <= 1'b1;
            HB_OUT      <= 1'b1;
            VB_OUT      <= 1'b1;
            col_q       <= '0;
            PALRAM_ADDR <= '0;
            OVERRUN     <= 1'b0;
            prime_cnt   <= 2'd0;
        end else if (PIXEL_CEN) begin
            idx_q  <= idx_sel;
            skip_q <= skip_sel;
            hb_s   <= HB;
            vb_s   <= VB;
            HB_OUT <= hb_s;
            VB_OUT <= vb_s;
            if (state != IDLE) begin
                OVERRUN <= 1'b1;
            end
            if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end else begin
            if (state == ADDR) begin
                if (blank_s) begin
                    PALRAM_ADDR <= '0;
                end else if (!skip_q) begin
                    PALRAM_ADDR <= PAL_AW'(idx_q);
                end
            end
            if (state == CAPTURE) begin
                col_q <= skip_q ? xbgr555_t'(16'h0000) : xbgr555_t'(PALRAM_DATA);
            end
        end
    end

    // Output stage sees col_q of the previous pixel; the first two strobes after reset stay black.
    bakraid_pal_expand u_expand (
        .clk         (CLK96),
        .rst         (RESET96),
        .load        (PIXEL_CEN),
        .force_black (blank_s | ~primed),
        .col         (col_q),
        .red         (RED),
        .green       (GREEN),
        .blue        (BLUE)
    );

endmodule

// File: tb/tb_bakraid_text_mixer.sv
// Directed bench for bakraid_text_mixer with a 1-cycle-latency palette RAM model.
module tb_bakraid_text_mixer;
    import bakraid_video_pkg::*;

    logic        CLK96 = 1'b0;
    logic        RESET96;
    logic        PIXEL_CEN;
    logic        HB;
    logic        VB;
    logic [10:0] EXTRATEXT_PIXEL;
    logic [10:0] LAYER_PIXEL;
    logic [10:0] PALRAM_ADDR;
    logic [15:0] PALRAM_DATA;
    logic [7:0]  RED;
    logic [7:0]  GREEN;
    logic [7:0]  BLUE;
    logic        HB_OUT;
    logic        VB_OUT;
    logic        OVERRUN;

    int errors = 0;
    int checks = 0;

    logic [15:0] pal_mem [0:2047];

    always #5 CLK96 = ~CLK96;

    always @(posedge CLK96) PALRAM_DATA <= pal_mem[PALRAM_ADDR];

    bakraid_text_mixer #(
        .PAL_AW      (11),
        .PALRAM_LAT  (1),
        .CEN_GAP_MIN (6)
    ) dut (
        .CLK96           (CLK96),
        .RESET96         (RESET96),
        .PIXEL_CEN       (PIXEL_CEN),
        .HB              (HB),
        .VB              (VB),
        .EXTRATEXT_PIXEL (EXTRATEXT_PIXEL),
        .LAYER_PIXEL     (LAYER_PIXEL),
        .PALRAM_ADDR     (PALRAM_ADDR),
        .PALRAM_DATA     (PALRAM_DATA),
        .RED             (RED),
        .GREEN           (GREEN),
        .BLUE            (BLUE),
        .HB_OUT          (HB_OUT),
        .VB_OUT          (VB_OUT),
        .OVERRUN         (OVERRUN)
    );

    typedef struct {
        logic [10:0] ext;
        logic [10:0] layer;
        logic        hb;
        logic        vb;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [10:0] addr;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered 1ns after an edge; returns 1ns after the strobe edge.
    task automatic pixel(input logic [10:0] e, input logic [10:0] l, input logic h, input logic v);
        EXTRATEXT_PIXEL = e;
        LAYER_PIXEL     = l;
        HB              = h;
        VB              = v;
        PIXEL_CEN       = 1'b1;
        @(posedge CLK96);
        #1;
        PIXEL_CEN       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK96);
            #1;
        end
    endtask

    task automatic chk_rgb(input string nm, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        chk({nm, "_r"}, 32'(RED), 32'(r));
        chk({nm, "_g"}, 32'(GREEN), 32'(g));
        chk({nm, "_b"}, 32'(BLUE), 32'(b));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) pal_mem[i] = 16'h1234;
        pal_mem[11'h000] = 16'h4210;
        pal_mem[11'h123] = 16'h7FFF;
        pal_mem[11'h045] = 16'h001F;
        pal_mem[11'h2A1] = 16'h03E0;
        pal_mem[11'h3B5] = 16'hC02A;

        //               ext     layer   hb    vb    R      G      B      addr
        vecs[0] = '{11'h123, 11'h045, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 11'h123};
        vecs[1] = '{11'h120, 11'h045, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 11'h045};
`ifdef BAKRAID_TEXTMIX_BACKDROP_EN
        vecs[2] = '{11'h000, 11'h000, 1'b0, 1'b0, 8'h84, 8'h84, 8'h84, 11'h000};
`else
        vecs[2] = '{11'h000, 11'h000, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 11'h045};
`endif
        vecs[3] = '{11'h3B5, 11'h045, 1'b0, 1'b0, 8'h52, 8'h08, 8'h84, 11'h3B5};
        vecs[4] = '{11'h2A1, 11'h045, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 11'h000};
        vecs[5] = '{11'h010, 11'h2A1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 11'h2A1};
        vecs[6] = '{11'h000, 11'h123, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 11'h000};
        vecs[7] = '{11'h3B5, 11'h000, 1'b0, 1'b0, 8'h52, 8'h08, 8'h84, 11'h3B5};

        RESET96 = 1'b1;
        PIXEL_CEN = 1'b0;
        HB = 1'b0;
        VB = 1'b0;
        EXTRATEXT_PIXEL = '0;
        LAYER_PIXEL = '0;
        idle(3);
        RESET96 = 1'b0;

        chk_rgb("reset", 8'h00, 8'h00, 8'h00);
        chk("reset_hb_out", 32'(HB_OUT), 32'd1);
        chk("reset_vb_out", 32'(VB_OUT), 32'd1);
        chk("reset_overrun", 32'(OVERRUN), 32'd0);
        chk("reset_addr", 32'(PALRAM_ADDR), 32'd0);

        // Two blanked warm-up pixels.
        pixel(11'h123, 11'h045, 1'b1, 1'b0);
        chk_rgb("warm0", 8'h00, 8'h00, 8'h00);
        idle(5);
        pixel(11'h123, 11'h045, 1'b1, 1'b0);
        chk_rgb("warm1", 8'h00, 8'h00, 8'h00);
        chk("warm1_hb_out", 32'(HB_OUT), 32'd1);
        idle(5);

        // Each strobe emits the pixel presented one strobe earlier.
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) pixel(vecs[i].ext, vecs[i].layer, vecs[i].hb, vecs[i].vb);
            else       pixel(11'h000, 11'h045, 1'b0, 1'b0);
            if (i > 0) begin
                chk_rgb($sformatf("vec%0d", i - 1), vecs[i-1].r, vecs[i-1].g, vecs[i-1].b);
                chk($sformatf("vec%0d_hb_out", i - 1), 32'(HB_OUT), 32'(vecs[i-1].hb));
                chk($sformatf("vec%0d_vb_out", i - 1), 32'(VB_OUT), 32'(vecs[i-1].vb));
                chk($sformatf("vec%0d_addr", i - 1), 32'(PALRAM_ADDR), 32'(vecs[i-1].addr));
                chk($sformatf("vec%0d_overrun", i - 1), 32'(OVERRUN), 32'd0);
            end
            idle(5);
        end

        // Overrun: second strobe two cycles after the first.
        pixel(11'h123, 11'h045, 1'b0, 1'b0);
        idle(1);
        pixel(11'h3B5, 11'h045, 1'b0, 1'b0);
        chk("ovr_set", 32'(OVERRUN), 32'd1);
        idle(5);
        pixel(11'h120, 11'h045, 1'b0, 1'b0);
        chk_rgb("ovr_next", 8'h52, 8'h08, 8'h84);
        chk("ovr_sticky0", 32'(OVERRUN), 32'd1);
        idle(5);
        pixel(11'h2A1, 11'h045, 1'b0, 1'b0);
        chk_rgb("ovr_next2", 8'hFF, 8'h00, 8'h00);
        chk("ovr_sticky1", 32'(OVERRUN), 32'd1);
        idle(5);

        // Reset while the lookup is in WAIT.
        pixel(11'h123, 11'h045, 1'b0, 1'b0);
        chk_rgb("pre_rst", 8'h00, 8'hFF, 8'h00);
        idle(1);
        chk("pre_rst_fsm_wait", 32'(dut.state), 32'(WAIT));
        RESET96 = 1'b1;
        idle(1);
        RESET96 = 1'b0;
        chk_rgb("mid_rst", 8'h00, 8'h00, 8'h00);
        chk("mid_rst_overrun", 32'(OVERRUN), 32'd0);
        chk("mid_rst_hb_out", 32'(HB_OUT), 32'd1);
        chk("mid_rst_fsm", 32'(dut.state), 32'(IDLE));
        idle(4);
        pixel(11'h123, 11'h045, 1'b1, 1'b0);
        chk_rgb("post_rst0", 8'h00, 8'h00, 8'h00);
        idle(5);
        pixel(11'h123, 11'h045, 1'b0, 1'b0);
        chk_rgb("post_rst1", 8'h00, 8'h00, 8'h00);
        idle(5);
        pixel(11'h2A1, 11'h045, 1'b0, 1'b0);
        chk_rgb("post_rst2", 8'hFF, 8'hFF, 8'hFF);
        chk("post_rst2_hb_out", 32'(HB_OUT), 32'd0);
        chk("post_rst2_overrun", 32'(OVERRUN), 32'd0);
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
